demux_1to5_128bit_reg: RTL and testbench

- Registered 1-to-5 demultiplexer for 128-bit AES state words, with valid/ready handshake on every side. It performs the inverse of the 5:1 round-datapath mux.
- It routes one 128-bit state, with a 3-bit destination index, to one of five consumers. The consumers are index 0 input load, 1 SubBytes, 2 ShiftRows, 3 MixColumns and 4 AddRoundKey.
- It sits between the round controller and the round stages and decouples their timing with a single-entry holding register.

---
 rtl/aes_pkg.sv | 31 +++
 rtl/hold_reg_128.sv | 86 ++++++++
 rtl/demux_1to5_128bit_reg.sv | 113 +++++++++++
 tb/tb_demux_1to5_128bit_reg.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the AES round datapath: state width, number of
// round stages, stage index constants and the 3-bit stage select type used
// by both the 5:1 round mux and the 1:5 demux.
// Also holds the state encoding of the single-entry holding register.
// ---------------------------------------------------------------------------
package aes_pkg;

    localparam int AES_STATE_W    = 128;
    localparam int AES_NUM_STAGES = 5;

    typedef logic [2:0] stage_sel_t;

    localparam stage_sel_t STG_LOAD  = 3'd0;
    localparam stage_sel_t STG_SUB   = 3'd1;
    localparam stage_sel_t STG_SHIFT = 3'd2;
    localparam stage_sel_t STG_MIX   = 3'd3;
    localparam stage_sel_t STG_ARK   = 3'd4;

    typedef enum logic [0:0] {
        HOLD_EMPTY = 1'b0,
        HOLD_FULL  = 1'b1
    } hold_state_t;

    // True when sel names an existing stage.
    function automatic logic sel_is_valid(input stage_sel_t sel, input stage_sel_t num_stages);
        return (sel < num_stages);
    endfunction

endpackage

// File: rtl/hold_reg_128.sv
// ---------------------------------------------------------------------------
// hold_reg_128
// Single-entry holding register (data + destination select + valid).
//
// Handshake: a word is written on any rising edge where wr_en=1; the parent
// only raises wr_en when the register is empty or is being drained in the
// same cycle. A held word leaves on the edge where rd_valid=1 and
// rd_ready=1 (drain). rd_valid never drops without a drain, and
// rd_data/rd_sel stay stable while rd_valid=1 and rd_ready=0.
//
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   wr_en       load wr_data/wr_sel this edge
//   wr_data     word to load
//   wr_sel      destination to load
//   rd_ready    consumer of the held word is ready
//   rd_valid    a word is held
//   rd_data     held word (keeps last value after draining)
//   rd_sel      destination of the held word
//   drain       held word leaves on this edge
//   state_dbg   current FSM state
// ---------------------------------------------------------------------------
module hold_reg_128
    import aes_pkg::*;
#(
    parameter int WIDTH = AES_STATE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [2:0]       wr_sel,
    input  logic             rd_ready,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic [2:0]       rd_sel,
    output logic             drain,
    output hold_state_t      state_dbg
);

    hold_state_t state_q;
    hold_state_t state_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HOLD_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rd_valid = 1'b0;
        drain    = 1'b0;
        case (state_q)
            HOLD_EMPTY: begin
                if (wr_en) begin
                    state_d = HOLD_FULL;
                end
            end
            HOLD_FULL: begin
                rd_valid = 1'b1;
                drain    = rd_ready;
                // A simultaneous drain and write keeps the register full.
                if (rd_ready && !wr_en) begin
                    state_d = HOLD_EMPTY;
                end
            end
            default: state_d = HOLD_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
            rd_sel  <= '0;
        end else if (wr_en) begin
            rd_data <= wr_data;
            rd_sel  <= wr_sel;
        end
    end

    assign state_dbg = state_q;

endmodule

// File: rtl/demux_1to5_128bit_reg.sv
// ---------------------------------------------------------------------------
// demux_1to5_128bit_reg
// Registered 1-to-5 demultiplexer for 128-bit AES state words. Routes one
// state word with a 3-bit destination index to one of five round stages
// (0 load, 1 SubBytes, 2 ShiftRows, 3 MixColumns, 4 AddRoundKey) through a
// single-entry holding register.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   in_data    state word to route
//   in_sel     destination index 0..4
//   in_valid   in_data/in_sel valid
//   in_ready   word accepted this cycle (combinational)
//   out_data   held word, shared by all channels
//   out_valid  one-hot, bit i = channel i holds a word
//   out_ready  per-channel consumer ready
//   err_sel    sticky: a word with an invalid in_sel was accepted
//   drop_cnt   (only with DEMUX_DROP_COUNT_EN) saturating count of
//              accepted invalid-sel words
//
// Build option: define DEMUX_DROP_COUNT_EN to add the drop_cnt counter.
// ---------------------------------------------------------------------------
module demux_1to5_128bit_reg
    import aes_pkg::*;
#(
    parameter int WIDTH   = AES_STATE_W,
    parameter int NUM_OUT = AES_NUM_STAGES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [2:0]         in_sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [NUM_OUT-1:0] out_valid,
    input  logic [NUM_OUT-1:0] out_ready,
    output logic               err_sel
`ifdef DEMUX_DROP_COUNT_EN
    ,
    output logic [7:0]         drop_cnt
`endif
);

    localparam stage_sel_t NUM_OUT_SEL = stage_sel_t'(NUM_OUT);

    logic        accept;
    logic        sel_ok;
    logic        load;
    logic        held;
    logic        drain;
    logic        sel_ready;
    stage_sel_t  sel_q;
    hold_state_t hold_state;

    assign sel_ok = sel_is_valid(in_sel, NUM_OUT_SEL);
    assign accept = in_valid & in_ready;
    // Invalid-sel words are consumed but never written into the register.
    assign load   = accept & sel_ok;

    // Only the selected channel's ready matters; out_valid is one-hot so
    // the reduction picks exactly that bit.
    assign sel_ready = |(out_valid & out_ready);

    // Space is available when empty, or when the held word leaves this edge.
    assign in_ready = !rst & (!held | drain);

    hold_reg_128 #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (load),
        .wr_data   (in_data),
        .wr_sel    (in_sel),
        .rd_ready  (sel_ready),
        .rd_valid  (held),
        .rd_data   (out_data),
        .rd_sel    (sel_q),
        .drain     (drain),
        .state_dbg (hold_state)
    );

    // One-hot expansion of the held select.
    always_comb begin
        out_valid = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            out_valid[i] = held && (sel_q == stage_sel_t'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_sel <= 1'b0;
        end else if (accept && !sel_ok) begin
            err_sel <= 1'b1;
        end
    end

`ifdef DEMUX_DROP_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= 8'h00;
        end else if (accept && !sel_ok && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'h01;
        end
    end
`else
    // No drop counter in this build; err_sel alone records invalid selects.
`endif

endmodule

// File: tb/tb_demux_1to5_128bit_reg.sv
module tb_demux_1to5_128bit_reg;

    localparam int W = 128;
    localparam int N = 5;

    logic           clk;
    logic           rst;
    logic [W-1:0]   in_data;
    logic [2:0]     in_sel;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   out_data;
    logic [N-1:0]   out_valid;
    logic [N-1:0]   out_ready;
    logic           err_sel;
`ifdef DEMUX_DROP_COUNT_EN
    logic [7:0]     drop_cnt;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    demux_1to5_128bit_reg dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_sel   (err_sel)
`ifdef DEMUX_DROP_COUNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    // Clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic         valid;
        logic [2:0]   sel;
        logic [W-1:0] data;
        logic [N-1:0] ready;
        logic         exp_in_ready;
        logic [N-1:0] exp_valid;
        logic [W-1:0] exp_data;
        logic         exp_err;
        logic [7:0]   exp_drop;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic v, input logic [2:0] s, input logic [W-1:0] d,
                       input logic [N-1:0] rdy, input logic eir, input logic [N-1:0] ev,
                       input logic [W-1:0] ed, input logic ee, input logic [7:0] edc);
        vec_t t;
        t.rst = r; t.valid = v; t.sel = s; t.data = d; t.ready = rdy;
        t.exp_in_ready = eir; t.exp_valid = ev; t.exp_data = ed;
        t.exp_err = ee; t.exp_drop = edc;
        vecs.push_back(t);
    endtask

    // Driver: inputs are applied just after a rising edge, in_ready is
    // sampled mid-cycle, registered outputs just after the next edge.
    task automatic apply(input vec_t t, input string tag);
        rst       = t.rst;
        in_valid  = t.valid;
        in_sel    = t.sel;
        in_data   = t.data;
        out_ready = t.ready;
        #4;
        chk({tag, " in_ready"}, W'(in_ready), W'(t.exp_in_ready));
        @(posedge clk);
        #1;
        chk({tag, " out_valid"}, W'(out_valid), W'(t.exp_valid));
        chk({tag, " out_data"}, out_data, t.exp_data);
        chk({tag, " err_sel"}, W'(err_sel), W'(t.exp_err));
`ifdef DEMUX_DROP_COUNT_EN
        chk({tag, " drop_cnt"}, W'(drop_cnt), W'(t.exp_drop));
`endif
    endtask

    initial begin
        logic [W-1:0] da, db, dc, dd, de, df, z;
        da = {16{8'hAA}}; db = {16{8'hBB}}; dc = {16{8'hCC}};
        dd = {16{8'hDD}}; de = {16{8'hEE}}; df = {16{8'hFF}}; z = '0;

        rst = 1'b1; in_valid = 1'b0; in_sel = 3'd0; in_data = z; out_ready = '0;

        //   rst v  sel   data rdy       eir  exp_valid  data err drop
        // reset with in_valid held high
        add(1, 1, 3'd2, dc, 5'b00000, 0, 5'b00000, z,  0, 8'd0);
        add(1, 1, 3'd2, dc, 5'b00000, 0, 5'b00000, z,  0, 8'd0);
        // single route to channel 2, then backpressure, then drain
        add(0, 1, 3'd2, dc, 5'b00000, 1, 5'b00100, dc, 0, 8'd0);
        add(0, 0, 3'd6, da, 5'b00000, 0, 5'b00100, dc, 0, 8'd0);
        add(0, 0, 3'd1, da, 5'b00100, 1, 5'b00000, dc, 0, 8'd0);
        // back-to-back sweep with all consumers ready
        add(0, 1, 3'd0, da, 5'b11111, 1, 5'b00001, da, 0, 8'd0);
        add(0, 1, 3'd1, db, 5'b11111, 1, 5'b00010, db, 0, 8'd0);
        add(0, 1, 3'd2, dc, 5'b11111, 1, 5'b00100, dc, 0, 8'd0);
        add(0, 1, 3'd3, dd, 5'b11111, 1, 5'b01000, dd, 0, 8'd0);
        add(0, 1, 3'd4, de, 5'b11111, 1, 5'b10000, de, 0, 8'd0);
        add(0, 0, 3'd0, da, 5'b11111, 1, 5'b00000, de, 0, 8'd0);
        // backpressure on channel 1 while DD is offered for channel 3;
        // ready on the other channels must be ignored
        add(0, 1, 3'd1, db, 5'b00000, 1, 5'b00010, db, 0, 8'd0);
        for (int i = 0; i < 4; i++)
            add(0, 1, 3'd3, dd, 5'b11101, 0, 5'b00010, db, 0, 8'd0);
        add(0, 1, 3'd3, dd, 5'b00010, 1, 5'b01000, dd, 0, 8'd0);
        add(0, 0, 3'd3, dd, 5'b01000, 1, 5'b00000, dd, 0, 8'd0);
        // invalid sel while empty
        add(0, 1, 3'd5, df, 5'b00000, 1, 5'b00000, dd, 1, 8'd1);
        add(0, 0, 3'd0, df, 5'b00000, 1, 5'b00000, dd, 1, 8'd1);
        // invalid sel coinciding with a drain empties the register
        add(0, 1, 3'd0, da, 5'b00000, 1, 5'b00001, da, 1, 8'd1);
        add(0, 1, 3'd7, df, 5'b00001, 1, 5'b00000, da, 1, 8'd2);
        // invalid sel offered while full and stalled is not accepted
        add(0, 1, 3'd2, dc, 5'b00000, 1, 5'b00100, dc, 1, 8'd2);
        add(0, 1, 3'd6, df, 5'b11011, 0, 5'b00100, dc, 1, 8'd2);
        add(0, 0, 3'd6, df, 5'b00100, 1, 5'b00000, dc, 1, 8'd2);
        // mid-operation reset while full on channel 4
        add(0, 1, 3'd4, de, 5'b00000, 1, 5'b10000, de, 1, 8'd2);
        add(1, 1, 3'd0, da, 5'b00000, 0, 5'b00000, z,  0, 8'd0);
        add(0, 1, 3'd1, db, 5'b00000, 1, 5'b00010, db, 0, 8'd0);
        add(0, 0, 3'd1, db, 5'b00010, 1, 5'b00000, db, 0, 8'd0);

        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Hand sequence: 300 back-to-back invalid words; each must be
        // accepted, none may appear on an output, the counter saturates.
        for (int i = 0; i < 300; i++) begin
            rst = 1'b0; in_valid = 1'b1; in_sel = 3'(5 + (i % 3)); in_data = df; out_ready = '0;
            #4;
            if (i == 0 || i == 299) chk($sformatf("inv%0d in_ready", i), W'(in_ready), W'(1'b1));
            @(posedge clk);
            #1;
            if (i == 0) begin
                chk("inv0 err_sel", W'(err_sel), W'(1'b1));
`ifdef DEMUX_DROP_COUNT_EN
                chk("inv0 drop_cnt", W'(drop_cnt), W'(8'd1));
`endif
            end
        end
        chk("inv_end out_valid", W'(out_valid), W'(5'b00000));
        chk("inv_end out_data", out_data, db);
        chk("inv_end err_sel", W'(err_sel), W'(1'b1));
`ifdef DEMUX_DROP_COUNT_EN
        chk("inv_end drop_cnt", W'(drop_cnt), W'(8'hFF));
`endif

        // Hand sequence: a valid word after the invalid burst routes normally.
        in_valid = 1'b1; in_sel = 3'd3; in_data = dd; out_ready = '0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("post_inv out_valid", W'(out_valid), W'(5'b01000));
        chk("post_inv out_data", out_data, dd);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
